run_monitor: RTL
================

Name: run_monitor

Overview:
- Synthesizable run-control and debug monitor for the nrisc core; replaces ad-hoc halt detection in simulation tops.
- Gates the core via `halt`, detects a configurable halt opcode, and enforces a stall watchdog.
- Counts cycles and retired instructions, and keeps a circular trace of recent PCs.
- Sits between the nrisc core and memory; `halt` drives both.

Parameters:
- DATA_W, 8: instruction width.
- ADDR_W, 8: PC width.
- HALT_MASK, 8'b11100011: bits of `instr` compared for halt (default matches pattern 110xxx11).
- HALT_MATCH, 8'b11000011: required value of masked bits.
- CNT_W, 16: width of cycle and instruction counters.
- TRACE_DEPTH, 8: trace entries; power of two, >= 2.
- TIMEOUT, 1000: consecutive cycles with unchanged PC before a stall halt; 0 disables the watchdog.

Ports:
- c, input, 1: clock, rising edge.
- reset, input, 1: synchronous, active-high.
- start, input, 1: pulse; IDLE -> RUN.
- step, input, 1: pulse; execute exactly one cycle from IDLE.
- stop_req, input, 1: external stop.
- clear, input, 1: HALTED -> IDLE, clears counters and trace.
- instr, input, DATA_W: current instruction from memory.
- pc, input, ADDR_W: current core PC.
- halt, output, 1: 1 = core/memory frozen.
- halt_cause, output, 2: 00 none, 01 halt opcode, 10 watchdog, 11 stop_req.
- cycle_count, output, CNT_W: cycles spent in RUN/STEP.
- instr_count, output, CNT_W: retired instructions.
- trace_rd_idx, input, log2(TRACE_DEPTH): 0 = most recent entry.
- trace_pc, output, ADDR_W: combinational read of the selected entry.
- trace_fill, output, log2(TRACE_DEPTH)+1: valid entries, saturates at TRACE_DEPTH.

Behaviour:
- **Reset:** state=IDLE, halt=1, halt_cause=00, counters=0, trace_fill=0, write pointer=0, watchdog=0. Reset overrides everything, mid-run included.
- **Output decode:** `halt` = 1 in IDLE and HALTED, 0 in RUN and STEP; decoded from the registered state, no combinational path from inputs.

State transitions:
- **IDLE:**
  - start -> RUN.
  - else step -> STEP; start wins if both.
  - clear in IDLE also zeroes counters and trace.
- **RUN / STEP, each cycle** (these are the retire actions):
  - cycle_count+1 and instr_count+1, both saturating at all-ones.
  - Push `pc` into the trace at the write pointer; pointer wraps modulo TRACE_DEPTH; trace_fill+1 up to TRACE_DEPTH.
- **RUN priority, same edge:**
  1. stop_req -> HALTED, cause 11.
  2. (instr & HALT_MASK) == HALT_MATCH -> HALTED, cause 01. The halt instruction is counted and traced; halt=1 from the next cycle.
  3. Watchdog reaches TIMEOUT -> HALTED, cause 10.
  4. Otherwise stay in RUN.
- **Watchdog:** 0 on entry to RUN; +1 each RUN cycle where pc equals the previous-cycle pc; reset to 0 when pc changes.
- **STEP:** one cycle only, with the same retire actions and the same halt/stop checks. Then -> HALTED if a condition fired, else -> IDLE. The watchdog is not evaluated in STEP.
- **HALTED:**
  - halt=1; cause, counters and trace held.
  - start and step ignored.
  - clear -> IDLE with cause=00, counters=0, trace_fill=0, pointer=0.
- **Trace read:** entry = buffer[(wr_ptr - 1 - trace_rd_idx) mod TRACE_DEPTH]. Reading idx >= trace_fill returns stale data; callers check trace_fill.
- **Trace wrap:** after TRACE_DEPTH+k pushes, the oldest k entries are overwritten.

Test Plan:
- Reset, then start. Program PCs 0,1,2, with instr at PC 3 = 8'b11010111 -> halt rises the cycle after PC 3 is sampled; cause=01; instr_count=4; trace_pc[idx0]=3, [idx3]=0; trace_fill=4.
- TIMEOUT=5 override, pc held at 8'h10 in RUN -> HALTED on the 6th RUN cycle with cause=10; cycle_count=6.
- Run 12 cycles with PC 0..11 then stop_req, TRACE_DEPTH=8 -> cause=11; trace_fill=8; trace_pc[idx0]=11, [idx7]=4 (wrap).
- Step from IDLE, three times -> each pulse gives exactly one halt=0 cycle; instr_count=3; state back to IDLE, cause=00.
- start and step in the same cycle -> RUN entered; stop_req together with a halt opcode -> cause=11.
- Reset asserted mid-RUN; separately, clear in HALTED -> IDLE, halt=1, all counters 0, trace_fill 0; a subsequent start resumes counting from 1.

Source files
------------

// File: rtl/run_monitor.sv
// Run-control and debug monitor for the nrisc core: gates the core via halt, detects a halt opcode,
// runs a stall watchdog, counts cycles and retired instructions, and keeps a circular PC trace.
module run_monitor #(
    parameter int                 DATA_W      = 8,
    parameter int                 ADDR_W      = 8,
    parameter logic [DATA_W-1:0]  HALT_MASK   = 8'b11100011,
    parameter logic [DATA_W-1:0]  HALT_MATCH  = 8'b11000011,
    parameter int                 CNT_W       = 16,
    parameter int                 TRACE_DEPTH = 8,
    parameter int                 TIMEOUT     = 1000,
    localparam int                PW          = $clog2(TRACE_DEPTH)
) (
    input  logic              c,
    input  logic              reset,
    input  logic              start,
    input  logic              step,
    input  logic              stop_req,
    input  logic              clear,
    input  logic [DATA_W-1:0] instr,
    input  logic [ADDR_W-1:0] pc,
    output logic              halt,
    output logic [1:0]        halt_cause,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count,
    input  logic [PW-1:0]     trace_rd_idx,
    output logic [ADDR_W-1:0] trace_pc,
    output logic [PW:0]       trace_fill
);

    localparam int              WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
    localparam logic [PW:0]     FILL_MAX = (PW + 1)'(TRACE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_HALTED
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          cause_q, cause_d;
    logic [CNT_W-1:0]    cyc_q, cyc_d;
    logic [CNT_W-1:0]    ins_q, ins_d;
    logic [PW-1:0]       wr_q, wr_d;
    logic [PW:0]         fill_q, fill_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                pv_q, pv_d;
    logic [ADDR_W-1:0]   prev_q, prev_d;
    logic [ADDR_W-1:0]   mem_q [TRACE_DEPTH];

    logic                push;
    logic                clr;
    logic                op_hit;
    logic                wd_fire;
    logic [PW-1:0]       rd_ptr;

    assign op_hit = (instr & HALT_MASK) == HALT_MATCH;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cyc_d   = cyc_q;
        ins_d   = ins_q;
        wr_d    = wr_q;
        fill_d  = fill_q;
        wd_d    = '0;
        pv_d    = 1'b0;
        prev_d  = prev_q;
        push    = 1'b0;
        clr     = 1'b0;
        wd_fire = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                clr = clear;
                if (start)     state_d = S_RUN;
                else if (step) state_d = S_STEP;
            end
            S_RUN, S_STEP: begin
                push = 1'b1;
                // pv_q marks that prev_q holds the pc of the previous RUN cycle.
                if (state_q == S_RUN) begin
                    wd_d    = (pv_q && pc == prev_q) ? wd_q + WD_W'(1) : '0;
                    pv_d    = 1'b1;
                    prev_d  = pc;
                    wd_fire = (TIMEOUT != 0) && (wd_d == WD_LIMIT);
                end
                if (stop_req) begin
                    state_d = S_HALTED;
                    cause_d = 2'b11;
                end else if (op_hit) begin
                    state_d = S_HALTED;
                    cause_d = 2'b01;
                end else if (wd_fire) begin
                    state_d = S_HALTED;
                    cause_d = 2'b10;
                end else if (state_q == S_STEP) begin
                    state_d = S_IDLE;
                end
            end
            S_HALTED: begin
                if (clear) begin
                    state_d = S_IDLE;
                    cause_d = 2'b00;
                    clr     = 1'b1;
                end
            end
        endcase
        if (push) begin
            cyc_d  = (&cyc_q) ? cyc_q : cyc_q + CNT_W'(1);
            ins_d  = (&ins_q) ? ins_q : ins_q + CNT_W'(1);
            wr_d   = wr_q + PW'(1);
            fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + (PW + 1)'(1);
        end
        if (clr) begin
            cyc_d  = '0;
            ins_d  = '0;
            wr_d   = '0;
            fill_d = '0;
        end
    end

    always_ff @(posedge c) begin
        if (reset) begin
            state_q <= S_IDLE;
            cause_q <= 2'b00;
            cyc_q   <= '0;
            ins_q   <= '0;
            wr_q    <= '0;
            fill_q  <= '0;
            wd_q    <= '0;
            pv_q    <= 1'b0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cyc_q   <= cyc_d;
            ins_q   <= ins_d;
            wr_q    <= wr_d;
            fill_q  <= fill_d;
            wd_q    <= wd_d;
            pv_q    <= pv_d;
            prev_q  <= prev_d;
        end
    end

    // Trace storage is not reset; trace_fill says which entries are meaningful.
    always_ff @(posedge c) begin
        if (!reset && push) mem_q[wr_q] <= pc;
    end

    assign rd_ptr      = wr_q - PW'(1) - trace_rd_idx;
    assign trace_pc    = mem_q[rd_ptr];
    assign halt        = (state_q == S_IDLE) || (state_q == S_HALTED);
    assign halt_cause  = cause_q;
    assign cycle_count = cyc_q;
    assign instr_count = ins_q;
    assign trace_fill  = fill_q;

endmodule
